// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared scan states and 7-segment constants
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    GUARD = 2'd2
  } scan_state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ALL   = 7'h00;

  // Hex glyphs 0..F, entry 15 listed first
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational hex nibble to active-low segment decode
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed 7-segment scan controller with guard blanking
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int DWELL_TICKS = 4,
  parameter int GUARD_TICKS = 1,
  localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dig_en,
  input  logic                  lamp_test,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]      cur_digit,
  output logic                  frame_done
);

  // Terminal counts; the counter clears on every state entry so it never wraps
  localparam logic [7:0] DWELL_LAST = 8'(DWELL_TICKS - 1);
  localparam logic [7:0] GUARD_LAST = 8'(GUARD_TICKS - 1);

  scan_state_t           state, state_nx;
  logic [7:0]            cnt, cnt_nx;
  logic [IDX_W-1:0]      cur_nx;
  logic                  fd_nx;
  logic [IDX_W-1:0]      lowest_idx, above_idx;
  logic                  above_found;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_nx;
  logic [N_DIGITS-1:0]   an_nx;

  // Find the lowest enabled digit and the nearest enabled digit above the current one
  always_comb begin
    lowest_idx  = '0;
    above_idx   = '0;
    above_found = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (dig_en[i]) begin
        lowest_idx = IDX_W'(i);
        if (i > int'(cur_digit)) begin
          above_idx   = IDX_W'(i);
          above_found = 1'b1;
        end
      end
    end
  end

  // Next-state logic: all sequencing happens only on tick
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cur_nx   = cur_digit;
    fd_nx    = 1'b0;
    if (tick) begin
      if (dig_en == '0) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
        case (state)
          IDLE: begin
            state_nx = SHOW;
            cur_nx   = lowest_idx;
            cnt_nx   = '0;
          end
          SHOW: begin
            if (!dig_en[cur_digit] || (cnt == DWELL_LAST)) begin
              state_nx = GUARD;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 8'd1;
            end
          end
          GUARD: begin
            if (cnt == GUARD_LAST) begin
              state_nx = SHOW;
              cnt_nx   = '0;
              cur_nx   = above_found ? above_idx : lowest_idx;
              fd_nx    = !above_found;
            end else begin
              cnt_nx = cnt + 8'd1;
            end
          end
          default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        endcase
      end
    end
  end

  // Select the nibble of the digit that will be lit after this edge
  always_comb begin
    nibble = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IDX_W'(i) == cur_nx) begin
        nibble = digits[4*i +: 4];
      end
    end
  end

  seg7_decoder u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // Output values to register: blank unless the next state is SHOW
  always_comb begin
    an_nx  = '1;
    seg_nx = SEG_BLANK;
    if (state_nx == SHOW) begin
      an_nx[cur_nx] = 1'b0;
      seg_nx        = lamp_test ? SEG_ALL : dec_seg;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_digit  <= '0;
      frame_done <= 1'b0;
      an         <= '1;
      seg        <= SEG_BLANK;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      cur_digit  <= cur_nx;
      frame_done <= fd_nx;
      an         <= an_nx;
      seg        <= seg_nx;
    end
  end

endmodule
